// File: rtl/pipeline_share_arbiter.sv
// Round-robin front end sharing one external register pipeline among NUM_REQ requesters,
// with a shadow valid/ID shift register tagging each word. Optional lock: PIPE_SHARE_LOCK_EN.
module pipeline_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WORD_WIDTH = 32,
  parameter int PIPE_DEPTH = 3,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OCC_W     = $clog2(PIPE_DEPTH + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data_i,
`ifdef PIPE_SHARE_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock_i,
`endif
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          pipe_clk_en_o,
  output logic [WORD_WIDTH-1:0]         pipe_data_o,
  input  logic [WORD_WIDTH-1:0]         pipe_data_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [WORD_WIDTH-1:0]         rsp_data_o,
  output logic [OCC_W-1:0]              occupancy_o
);

  if (PIPE_DEPTH < 1) begin : g_bad_depth
    $error("pipeline_share_arbiter: PIPE_DEPTH must be >= 1");
  end

  logic [PIPE_DEPTH-1:0] valid_q, valid_d;
  logic [ID_W-1:0]       id_q [PIPE_DEPTH];
  logic [ID_W-1:0]       id_d [PIPE_DEPTH];
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  have_win_q, have_win_d;

  logic                  advance;
  logic                  accept;
  logic                  grant_any;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       idx;

  // Advance depends only on shadow state and downstream ready, never on requester valids.
  assign advance       = ~valid_q[PIPE_DEPTH-1] | rsp_ready_i;
  assign accept        = valid_q[PIPE_DEPTH-1] & rsp_ready_i;
  assign pipe_clk_en_o = advance;

  // Arbitration: round-robin from ptr+1, optionally overridden by a held lock.
  always_comb begin
    grant_any = 1'b0;
    win_id    = '0;
    idx       = '0;
    if (advance && !rst_i) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        idx = ID_W'((32'(ptr_q) + i) % NUM_REQ);
        if (!grant_any && req_valid_i[idx]) begin
          grant_any = 1'b1;
          win_id    = idx;
        end else begin
          grant_any = grant_any;
        end
      end
`ifdef PIPE_SHARE_LOCK_EN
      if (have_win_q && req_valid_i[ptr_q] && req_lock_i[ptr_q]) begin
        grant_any = 1'b1;
        win_id    = ptr_q;
      end else begin
        win_id = win_id;
      end
`endif
    end else begin
      grant_any = 1'b0;
    end
  end

  // Grant outputs: one-hot ready and the winning word onto the pipeline input.
  always_comb begin
    req_ready_o = '0;
    pipe_data_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_any && (win_id == ID_W'(k))) begin
        req_ready_o[k] = 1'b1;
        pipe_data_o    = req_data_i[k*WORD_WIDTH +: WORD_WIDTH];
      end else begin
        req_ready_o[k] = 1'b0;
      end
    end
  end

  // Next state of the shadow stages, round-robin pointer and occupancy.
  always_comb begin
    valid_d    = valid_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    have_win_d = have_win_q;
    occ_d      = occ_q;
    if (advance) begin
      for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
        valid_d[i] = valid_q[i-1];
        id_d[i]    = id_q[i-1];
      end
      valid_d[0] = grant_any;
      id_d[0]    = win_id;
    end else begin
      valid_d = valid_q;
    end
    if (grant_any) begin
      ptr_d      = win_id;
      have_win_d = 1'b1;
    end else begin
      ptr_d = ptr_q;
    end
    case ({grant_any, accept})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers with synchronous reset; ptr resets so requester 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= '0;
      id_q       <= '{default: '0};
      ptr_q      <= ID_W'(NUM_REQ - 1);
      have_win_q <= 1'b0;
      occ_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      have_win_q <= have_win_d;
      occ_q      <= occ_d;
    end
  end

  // Reset hides the stale output stage so no in-flight word can complete.
  assign rsp_valid_o = valid_q[PIPE_DEPTH-1] & ~rst_i;
  assign rsp_id_o    = id_q[PIPE_DEPTH-1];
  assign rsp_data_o  = pipe_data_i;
  assign occupancy_o = rst_i ? '0 : occ_q;

endmodule

// File: tb/tb_pipeline_share_arbiter.sv
// Directed table-driven bench for pipeline_share_arbiter with a behavioural model of
// the shared 3-stage register pipeline; lock sequence runs when PIPE_SHARE_LOCK_EN is defined.
module tb_pipeline_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        pipe_clk_en;
  logic [31:0] pipe_data_o;
  logic [31:0] pipe_data_i;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic [1:0]  occupancy;
`ifdef PIPE_SHARE_LOCK_EN
  logic [3:0]  req_lock;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       rdy;
    logic [3:0] exp_rdy;
    logic       exp_en;
    logic       exp_rv;
    logic [1:0] exp_id;
    logic [1:0] exp_occ;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  pipeline_share_arbiter #(.NUM_REQ(4), .WORD_WIDTH(32), .PIPE_DEPTH(3)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_data_i    (req_data),
`ifdef PIPE_SHARE_LOCK_EN
    .req_lock_i    (req_lock),
`endif
    .req_ready_o   (req_ready),
    .pipe_clk_en_o (pipe_clk_en),
    .pipe_data_o   (pipe_data_o),
    .pipe_data_i   (pipe_data_i),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_id_o      (rsp_id),
    .rsp_data_o    (rsp_data),
    .occupancy_o   (occupancy)
  );

  // Model of the shared external pipeline: three enable-gated word registers.
  logic [31:0] pipe_q [3];
  always @(posedge clk) begin
    if (pipe_clk_en) begin
      pipe_q[0] <= pipe_data_o;
      pipe_q[1] <= pipe_q[0];
      pipe_q[2] <= pipe_q[1];
    end
  end
  assign pipe_data_i = pipe_q[2];

  // Requester k always offers word 0xA4+k.
  assign req_data = {32'h0000_00A7, 32'h0000_00A6, 32'h0000_00A5, 32'h0000_00A4};

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  function automatic logic [31:0] grant_word(input logic [3:0] onehot);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (onehot[k]) w = 32'h0000_00A4 + 32'(k);
    end
    return w;
  endfunction

  initial begin
    // reset (1 preamble cycle + 2 table cycles), single req1 word, reset
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0});
    // fairness: all valid, grants 0,1,2,3,0,1
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 2'd2});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd0, 2'd3});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd1, 2'd3});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd2, 2'd3});
    // stall 5 cycles with full pipe, then resume and drain
    for (int s = 0; s < 5; s++)
      tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd3, 2'd3});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd3, 2'd3});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd3});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 2'd2});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 2'd1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0});
    // bubbles at the output do not block advance while rsp_ready is low
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd1});
    // accept + grant together, fill to 3, then reset mid-flight
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0, 2'd0, 2'd2});
    tbl.push_back('{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd0});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0});

    rst       = 1'b1;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
`ifdef PIPE_SHARE_LOCK_EN
    req_lock  = 4'b0000;
`endif
    @(posedge clk);

    foreach (tbl[n]) begin
      @(negedge clk);
      rst       = tbl[n].rst;
      req_valid = tbl[n].vld;
      rsp_ready = tbl[n].rdy;
      #1;
      chk("req_ready", n, 32'(req_ready), 32'(tbl[n].exp_rdy));
      chk("pipe_clk_en", n, 32'(pipe_clk_en), 32'(tbl[n].exp_en));
      chk("pipe_data_o", n, pipe_data_o, grant_word(tbl[n].exp_rdy));
      chk("rsp_valid", n, 32'(rsp_valid), 32'(tbl[n].exp_rv));
      chk("occupancy", n, 32'(occupancy), 32'(tbl[n].exp_occ));
      if (tbl[n].exp_rv) begin
        chk("rsp_id", n, 32'(rsp_id), 32'(tbl[n].exp_id));
        chk("rsp_data", n, rsp_data, 32'h0000_00A4 + 32'(tbl[n].exp_id));
      end
    end

`ifdef PIPE_SHARE_LOCK_EN
    // Lock: req2 wins alone, holds 3 more beats against all others, then rr resumes at 3, 0.
    @(negedge clk);
    rst = 1'b1; req_valid = 4'b0000; req_lock = 4'b0000; rsp_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; req_valid = 4'b0100; req_lock = 4'b0100;
    #1 chk("lock_first", 100, 32'(req_ready), 32'h4);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      req_valid = 4'b1111; req_lock = 4'b0100;
      #1 chk("lock_hold", 101 + b, 32'(req_ready), 32'h4);
    end
    @(negedge clk);
    req_lock = 4'b0000;
    #1 chk("lock_release3", 104, 32'(req_ready), 32'h8);
    @(negedge clk);
    #1 chk("lock_release0", 105, 32'(req_ready), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
